// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: pulls len words from a first-word-fall-through FIFO into a 2-entry skid buffer.
// Optional FIFO_RD_STALL_CNT_EN adds o_stall_cnt, a saturating count of empty-FIFO cycles during BURST.
module fifo_rd_ctrl #(
  parameter int bw     = 4,
  parameter int simd   = 1,
  parameter int len_bw = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [len_bw-1:0]    len,
  input  logic                 fifo_empty,
  input  logic [simd*bw-1:0]   fifo_out,
  output logic                 fifo_rd,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [simd*bw-1:0]   o_data,
  output logic                 o_busy,
  output logic                 o_done
`ifdef FIFO_RD_STALL_CNT_EN
  ,
  output logic [15:0]          o_stall_cnt
`endif
);

  localparam int W = simd * bw;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [len_bw-1:0]   remaining_q, remaining_d;
  logic [1:0]          buf_cnt_q, buf_cnt_d;
  logic [W-1:0]        buf0_q, buf0_d;
  logic [W-1:0]        buf1_q, buf1_d;
  logic                done_q, done_d;
  logic                push, pop;

  assign fifo_rd = (state_q == BURST) && !fifo_empty && (remaining_q != '0) && (buf_cnt_q < 2'd2);
  assign o_valid = (buf_cnt_q != 2'd0);
  assign o_data  = buf0_q;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = done_q;

  assign push = fifo_rd;
  assign pop  = o_valid && i_ready;

  // buf0 is always the oldest entry, so o_data comes straight from a register.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    case ({push, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) buf0_d = fifo_out;
        else                   buf1_d = fifo_out;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = fifo_out;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_out;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    if (push) remaining_d = remaining_q - len_bw'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            remaining_d = len;
            state_d     = BURST;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      BURST: begin
        if (remaining_d == '0) state_d = DRAIN;
      end
      DRAIN: begin
        if (buf_cnt_d == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      buf_cnt_q   <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      buf_cnt_q   <= buf_cnt_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      done_q      <= done_d;
    end
  end

`ifdef FIFO_RD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && start)
      stall_cnt_d = 16'd0;
    else if (state_q == BURST && fifo_empty && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= 16'd0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: upstream FIFO modelled as a queue, expected words queued at start.
module tb_fifo_rd_ctrl;
  localparam int BW = 4, SIMD = 2, LBW = 7, W = BW * SIMD;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [LBW-1:0] len = '0;
  logic           fifo_empty = 1'b1;
  logic [W-1:0]   fifo_out = '0;
  logic           i_ready = 1'b0;
  logic           fifo_rd, o_valid, o_busy, o_done;
  logic [W-1:0]   o_data;
`ifdef FIFO_RD_STALL_CNT_EN
  logic [15:0]    o_stall_cnt;
`endif

  fifo_rd_ctrl #(.bw(BW), .simd(SIMD), .len_bw(LBW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .fifo_empty(fifo_empty), .fifo_out(fifo_out), .fifo_rd(fifo_rd),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_busy(o_busy), .o_done(o_done)
`ifdef FIFO_RD_STALL_CNT_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  logic [W-1:0] up_q[$];
  logic [W-1:0] exp_q[$];
  bit  rd_seen = 0, stall_force = 0, rand_ready = 0, rand_stall = 0;
  bit  zero_start = 0, done_arm = 0, prev_rd = 0, mon_en = 0;
  int  ready_pct = 70, stall_pct = 25;
  int  cyc = 0, rd_total = 0;
  int  rd_cyc[$], pop_cyc[$];

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_up();
    fifo_empty = stall_force || (up_q.size() == 0);
    fifo_out   = (up_q.size() != 0) ? up_q[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_seen) begin
      if (up_q.size() > 0) void'(up_q.pop_front());
      rd_seen = 0;
    end
    if (rand_ready) i_ready = ($urandom_range(0, 99) < ready_pct);
    if (rand_stall) stall_force = ($urandom_range(0, 99) < stall_pct);
    drive_up();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) up_q.push_back(W'($urandom));
    drive_up();
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = LBW'(l);
    if (l == 0) zero_start = 1;
    else for (int i = 0; i < l; i++) exp_q.push_back(up_q[i]);
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    int i;
    for (i = 0; i < 3000; i++) begin
      tick();
      if (exp_q.size() == 0 && !o_busy && !o_done && !done_arm) begin
        ok = 1;
        break;
      end
    end
    check(ok, name, i, 3000);
  endtask

  task automatic check_zero_outputs(input string tag);
    check(fifo_rd == 0, {tag, "_fifo_rd"}, fifo_rd, 0);
    check(o_valid == 0, {tag, "_o_valid"}, o_valid, 0);
    check(o_busy == 0,  {tag, "_o_busy"},  o_busy, 0);
    check(o_done == 0,  {tag, "_o_done"},  o_done, 0);
    check(o_data == 0,  {tag, "_o_data"},  o_data, 0);
  endtask

  // Monitor: everything here is sampled mid-cycle, after inputs settle and before the next edge.
  always @(negedge clk) begin
    bit arm_next;
    cyc++;
    arm_next = 0;
    if (!reset_n || !mon_en) begin
      prev_rd  = 0;
      done_arm = 0;
    end else begin
      check(o_done == done_arm, "o_done", o_done, done_arm);
      if (zero_start) begin
        arm_next   = 1;
        zero_start = 0;
      end
      if (prev_rd) check(o_valid == 1, "rd_to_valid_latency", o_valid, 1);
      if (fifo_rd) begin
        check(!fifo_empty && o_busy, "rd_legal", {fifo_empty, o_busy}, 2'b01);
        rd_seen = 1;
        rd_total++;
        rd_cyc.push_back(cyc);
      end
      prev_rd = fifo_rd;
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check(0, "unexpected_valid", o_data, 0);
        end else begin
          check(o_data == exp_q[0], "o_data", o_data, exp_q[0]);
          if (i_ready) begin
            void'(exp_q.pop_front());
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) arm_next = 1;
          end
        end
      end
      done_arm = arm_next;
    end
  end

  initial begin
    int base, base2;
    logic [W-1:0] w;

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset_n = 1'b1;
    mon_en  = 1;
    tick();

    // Four back-to-back words with a ready sink
    w = 8'hA0; up_q.push_back(w);
    w = 8'hB0; up_q.push_back(w);
    w = 8'hC0; up_q.push_back(w);
    w = 8'hD0; up_q.push_back(w);
    drive_up();
    i_ready = 1'b1;
    rd_cyc.delete();
    pop_cyc.delete();
    do_start(4);
    wait_idle("burst4_timeout");
    check(rd_cyc.size() == 4, "burst4_rd_count", rd_cyc.size(), 4);
    check(pop_cyc.size() == 4, "burst4_pop_count", pop_cyc.size(), 4);
    if (rd_cyc.size() == 4 && pop_cyc.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check(rd_cyc[i] == rd_cyc[0] + i, "burst4_rd_consecutive", rd_cyc[i], rd_cyc[0] + i);
        check(pop_cyc[i] == rd_cyc[0] + 1 + i, "burst4_pop_cycle", pop_cyc[i], rd_cyc[0] + 1 + i);
      end

    // Backpressure: only two words may be taken while the sink is blocked
    fill(8);
    i_ready = 1'b0;
    base = rd_total;
    do_start(8);
    repeat (4) tick();
    check(rd_total - base == 2, "backpressure_rd_count", rd_total - base, 2);
    check(o_valid == 1, "backpressure_valid", o_valid, 1);
    i_ready = 1'b1;
    wait_idle("burst8_timeout");

    // Upstream empty for three cycles after the first read
    fill(3);
    base = rd_total;
    do_start(3);
    tick();
    check(rd_total - base == 1, "stall_first_rd", rd_total - base, 1);
    stall_force = 1;
    drive_up();
    base2 = rd_total;
    repeat (3) tick();
    check(rd_total == base2, "stall_no_rd", rd_total - base2, 0);
    stall_force = 0;
    drive_up();
    wait_idle("burst3_timeout");
`ifdef FIFO_RD_STALL_CNT_EN
    check(o_stall_cnt == 16'd3, "stall_cnt", o_stall_cnt, 3);
`endif

    // Zero-length request
    base = rd_total;
    do_start(0);
    check(o_busy == 0, "len0_busy", o_busy, 0);
    tick();
    check(o_busy == 0, "len0_busy_after", o_busy, 0);
    wait_idle("len0_timeout");
    check(rd_total == base, "len0_no_rd", rd_total - base, 0);

    // Reset after four reads of a ten-word burst
    fill(10);
    base = rd_total;
    do_start(10);
    for (int i = 0; i < 50 && (rd_total - base) < 4; i++) tick();
    check(rd_total - base == 4, "pre_reset_reads", rd_total - base, 4);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("midburst_reset");
    exp_q.delete();
    up_q.delete();
    rd_seen    = 0;
    zero_start = 0;
    drive_up();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    fill(2);
    base = rd_total;
    do_start(2);
    wait_idle("post_reset_timeout");
    check(rd_total - base == 2, "post_reset_rd_count", rd_total - base, 2);

    // A second start during BURST must not extend or restart the burst
    fill(10);
    i_ready = 1'b0;
    do_start(5);
    tick();
    start = 1'b1;
    len   = LBW'(5);
    tick();
    start = 1'b0;
    len   = '0;
    i_ready = 1'b1;
    wait_idle("ignored_start_timeout");
    check(up_q.size() == 5, "ignored_start_leftover", up_q.size(), 5);
    up_q.delete();
    drive_up();

    // Maximum length burst
    fill(127);
    base = rd_total;
    do_start(127);
    wait_idle("burst127_timeout");
    check(rd_total - base == 127, "burst127_rd_count", rd_total - base, 127);

    // Randomised bursts with random backpressure and upstream gaps
    rand_ready = 1;
    rand_stall = 1;
    for (int b = 0; b < 30; b++) begin
      int l;
      l = $urandom_range(0, 20);
      fill(l + $urandom_range(0, 3));
      do_start(l);
      wait_idle("random_burst_timeout");
    end
    rand_ready  = 0;
    rand_stall  = 0;
    stall_force = 0;
    drive_up();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter bw, default 4, lane bit width.
REQ-002 SHALL have parameter simd, default 1, lanes per word; word width W = simd*bw.
REQ-003 SHALL have parameter len_bw, default 7, burst-length field width (max burst 127).
REQ-004 SHALL have port clk, input, 1, single clock for all state.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, burst request pulse.
REQ-007 SHALL have port len, input, len_bw, burst length sampled with start.
REQ-008 SHALL have port fifo_empty, input, 1, from the upstream FIFO o_empty.
REQ-009 SHALL have port fifo_out, input, W, upstream FIFO read data, first-word-fall-through, valid whenever fifo_empty=0.
REQ-010 SHALL have port fifo_rd, output, 1, read strobe to the upstream FIFO rd.
REQ-011 SHALL have port o_valid, output, 1, downstream data valid.
REQ-012 SHALL have port i_ready, input, 1, downstream ready.
REQ-013 SHALL have port o_data, output, W, downstream data.
REQ-014 SHALL have port o_busy, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have port o_done, output, 1, one-cycle burst-complete pulse.

Function
REQ-016 SHALL implement states IDLE, BURST and DRAIN.
REQ-017 In IDLE, start=1 with len>0 SHALL load remaining<=len and go to BURST; start with len=0 SHALL pulse o_done next cycle and stay in IDLE.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 fifo_rd SHALL be combinational: state==BURST && !fifo_empty && remaining!=0 && buf_cnt<2.
REQ-020 On each fifo_rd=1 cycle, fifo_out SHALL be written into a 2-entry in-order skid buffer and remaining SHALL decrement by 1.
REQ-021 o_valid SHALL equal buf_cnt!=0; o_data SHALL be the oldest buffer entry, registered (not combinational from fifo_out).
REQ-022 A pop SHALL occur on o_valid && i_ready; simultaneous push and pop SHALL leave buf_cnt unchanged and preserve order.
REQ-023 Latency fifo_rd -> o_valid SHALL be exactly 1 cycle; with i_ready=1 and fifo_empty=0, throughput SHALL be 1 word per cycle.
REQ-024 o_data SHALL hold stable while o_valid=1 and i_ready=0.
REQ-025 When remaining reaches 0, BURST SHALL go to DRAIN; DRAIN SHALL go to IDLE when buf_cnt becomes 0, pulsing o_done for one cycle on that transition.
REQ-026 fifo_empty=1 mid-burst SHALL stall with no state change; reading resumes the cycle fifo_empty returns to 0.
REQ-027 fifo_rd SHALL never assert in IDLE or DRAIN, or while fifo_empty=1.

Reset
REQ-028 reset_n=0 SHALL immediately force state=IDLE, remaining=0, buf_cnt=0, fifo_rd=0, o_valid=0, o_busy=0, o_done=0, o_data=0.
REQ-029 Reset mid-burst SHALL discard buffered words with no o_done; the first start after release SHALL behave as from power-up.

Configuration
REQ-030 With macro FIFO_RD_STALL_CNT_EN defined, SHALL add output o_stall_cnt (16 bits), cleared on reset and on accepted start, incremented each BURST cycle with fifo_empty=1, and saturating at 16'hFFFF.
REQ-031 Without FIFO_RD_STALL_CNT_EN, port o_stall_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 start, len=4, FIFO holds A,B,C,D, i_ready=1 -> fifo_rd high 4 consecutive cycles; o_data A..D on 4 consecutive cycles from the cycle after the first fifo_rd; o_done one cycle after D's pop.
REQ-033 len=8, i_ready=0 for 5 cycles -> exactly 2 fifo_rd, buffer holds the first 2 words, o_data stable; after i_ready=1, all 8 words in order.
REQ-034 len=3, fifo_empty=1 for 3 cycles after the first read -> no fifo_rd during the gap; 3 words in order; o_stall_cnt=3 with FIFO_RD_STALL_CNT_EN.
REQ-035 start with len=0 -> no fifo_rd; o_done pulses the next cycle; o_busy stays 0.
REQ-036 reset_n low mid-burst of len=10 after 4 reads -> all outputs 0 immediately; a new start with len=2 then yields 2 words and one o_done.
REQ-037 start reasserted during BURST with len=5 -> ignored; the original burst completes with its length and produces one o_done.
